// File: rtl/seg_pkg.sv
// Shared constants, types and segment table for the seven-segment frame capture block.
package seg_pkg;

  localparam int unsigned DIGITS_DEF = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned CNT_W      = 8;

  // Active-low segment patterns, bit 6 = a ... bit 0 = g
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SETTLE      = 2'd1,
    CAPTURE     = 2'd2,
    WAIT_CHANGE = 2'd3
  } state_e;

  typedef struct packed {
    logic [NIB_W-1:0] nibble;
    logic             blank;
    logic             err;
  } seg_dec_t;

  // Encoder direction of the table, handy for generating legal bus traffic
  function automatic logic [SEG_W-1:0] seg_of_nibble(input logic [NIB_W-1:0] n);
    logic [SEG_W-1:0] s;
    case (n)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = SEG_A;
      4'hB:    s = SEG_B;
      4'hC:    s = SEG_C;
      4'hD:    s = SEG_D;
      4'hE:    s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_frame_capture_if.sv
// Multiplexed seven-segment display bus: the scanner drives it, the capture block snoops it.
interface seg_frame_capture_if #(
  parameter int unsigned DIGITS = seg_pkg::DIGITS_DEF
) ();
  logic [DIGITS-1:0]          AN;
  logic [seg_pkg::SEG_W-1:0]  LED;
  logic                       p;

  modport master (output AN, output LED, output p);
  modport slave  (input  AN, input  LED, input  p);
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern to nibble decoder with blank and illegal-pattern flags.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] led_i,
  output seg_dec_t         dec_o
);

  always_comb begin
    dec_o.nibble = 4'h0;
    dec_o.blank  = 1'b0;
    dec_o.err    = 1'b0;
    case (led_i)
      SEG_0:     dec_o.nibble = 4'h0;
      SEG_1:     dec_o.nibble = 4'h1;
      SEG_2:     dec_o.nibble = 4'h2;
      SEG_3:     dec_o.nibble = 4'h3;
      SEG_4:     dec_o.nibble = 4'h4;
      SEG_5:     dec_o.nibble = 4'h5;
      SEG_6:     dec_o.nibble = 4'h6;
      SEG_7:     dec_o.nibble = 4'h7;
      SEG_8:     dec_o.nibble = 4'h8;
      SEG_9:     dec_o.nibble = 4'h9;
      SEG_A:     dec_o.nibble = 4'hA;
      SEG_B:     dec_o.nibble = 4'hB;
      SEG_C:     dec_o.nibble = 4'hC;
      SEG_D:     dec_o.nibble = 4'hD;
      SEG_E:     dec_o.nibble = 4'hE;
      SEG_F:     dec_o.nibble = 4'hF;
      SEG_BLANK: dec_o.blank  = 1'b1;
      default:   dec_o.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_frame_capture.sv
// Snoops a multiplexed seven-segment bus and publishes each complete frame of digits,
// decimal points, blank digits and illegal patterns with a one-cycle valid pulse.
module seg_frame_capture
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS        = DIGITS_DEF,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_frame_capture_if.slave    bus,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic [DIGITS-1:0]     point_out,
  output logic [DIGITS-1:0]     blank_mask,
  output logic [DIGITS-1:0]     err_mask,
  output logic                  valid
);

  localparam int unsigned     SMP_W    = DIGITS + SEG_W + 1;
  localparam int unsigned     HEX_W    = NIB_W * DIGITS;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_L = CNT_W'(STABLE_CYCLES);
  // With a single required sample the first legal sample is already enough
  localparam state_e SETTLE_TGT = (STABLE_CYCLES <= 1) ? CAPTURE : SETTLE;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SMP_W-1:0]      smp_q, smp_d;
  logic [SMP_W-1:0]      prv_q, prv_d;
  logic [DIGITS-1:0]     cap_an_q, cap_an_d;
  logic [DIGITS-1:0]     seen_q, seen_d;
  logic [HEX_W-1:0]      wrk_hex_q, wrk_hex_d;
  logic [DIGITS-1:0]     wrk_pt_q, wrk_pt_d;
  logic [DIGITS-1:0]     wrk_bl_q, wrk_bl_d;
  logic [DIGITS-1:0]     wrk_er_q, wrk_er_d;
  logic [HEX_W-1:0]      hex_q, hex_d;
  logic [DIGITS-1:0]     pt_q, pt_d;
  logic [DIGITS-1:0]     bl_q, bl_d;
  logic [DIGITS-1:0]     er_q, er_d;
  logic                  valid_q, valid_d;

  logic [DIGITS-1:0]     smp_an;
  logic [DIGITS-1:0]     prv_an;
  logic [DIGITS-1:0]     cap_bit;
  logic                  an_legal;
  logic                  stable;
  seg_dec_t              dec;

  // Bus sample and previous sample; the FSM only ever looks at registered data
  assign smp_d  = {bus.AN, bus.LED, bus.p};
  assign prv_d  = smp_q;

  assign smp_an   = smp_q[SMP_W-1 -: DIGITS];
  assign prv_an   = prv_q[SMP_W-1 -: DIGITS];
  assign an_legal = ($countones(~smp_an) == 1);
  assign stable   = (smp_q == prv_q);
  // In CAPTURE the previous sample is the accepted one and its anode is one-hot low
  assign cap_bit  = ~prv_an;

  seg_pattern_decode u_decode (
    .led_i (prv_q[SEG_W:1]),
    .dec_o (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      smp_q     <= '0;
      prv_q     <= '0;
      cap_an_q  <= '0;
      seen_q    <= '0;
      wrk_hex_q <= '0;
      wrk_pt_q  <= '0;
      wrk_bl_q  <= '0;
      wrk_er_q  <= '0;
      hex_q     <= '0;
      pt_q      <= '0;
      bl_q      <= '0;
      er_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      smp_q     <= smp_d;
      prv_q     <= prv_d;
      cap_an_q  <= cap_an_d;
      seen_q    <= seen_d;
      wrk_hex_q <= wrk_hex_d;
      wrk_pt_q  <= wrk_pt_d;
      wrk_bl_q  <= wrk_bl_d;
      wrk_er_q  <= wrk_er_d;
      hex_q     <= hex_d;
      pt_q      <= pt_d;
      bl_q      <= bl_d;
      er_q      <= er_d;
      valid_q   <= valid_d;
    end
  end

  // Dwell tracking, digit capture and frame publication
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_an_d  = cap_an_q;
    seen_d    = seen_q;
    wrk_hex_d = wrk_hex_q;
    wrk_pt_d  = wrk_pt_q;
    wrk_bl_d  = wrk_bl_q;
    wrk_er_d  = wrk_er_q;
    hex_d     = hex_q;
    pt_d      = pt_q;
    bl_d      = bl_q;
    er_d      = er_q;
    valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (an_legal) begin
          cnt_d   = CNT_ONE;
          state_d = SETTLE_TGT;
        end
      end

      SETTLE: begin
        if (!an_legal) begin
          state_d = IDLE;
        end else if (!stable) begin
          cnt_d   = CNT_ONE;
          state_d = SETTLE_TGT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d >= STABLE_L) begin
            state_d = CAPTURE;
          end
        end
      end

      CAPTURE: begin
        cap_an_d = prv_an;
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (cap_bit[i]) begin
            wrk_hex_d[NIB_W*i +: NIB_W] = dec.nibble;
            wrk_pt_d[i]                 = ~prv_q[0];
            wrk_bl_d[i]                 = dec.blank;
            wrk_er_d[i]                 = dec.err;
          end
        end
        seen_d = seen_q | cap_bit;
        if (&seen_d) begin
          hex_d   = wrk_hex_d;
          pt_d    = wrk_pt_d;
          bl_d    = wrk_bl_d;
          er_d    = wrk_er_d;
          valid_d = 1'b1;
          seen_d  = '0;
        end
        state_d = WAIT_CHANGE;
      end

      WAIT_CHANGE: begin
        // Segment changes under an unchanged anode are deliberately ignored
        if (!an_legal) begin
          state_d = IDLE;
        end else if (smp_an != cap_an_q) begin
          cnt_d   = CNT_ONE;
          state_d = SETTLE_TGT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign hex_out    = hex_q;
  assign point_out  = pt_q;
  assign blank_mask = bl_q;
  assign err_mask   = er_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_seg_frame_capture.sv
// Bench for seg_frame_capture: directed display scans plus random scans against a frame-level model.
module tb_seg_frame_capture;
  import seg_pkg::*;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned STABLE   = 4;
  localparam int          LONG_MIN = 6;

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  pt;
    logic [3:0]  bl;
    logic [3:0]  er;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hex_out;
  logic [3:0]  point_out, blank_mask, err_mask;
  logic        valid;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  int exp_cnt = 0;

  logic [15:0] m_hex;
  logic [3:0]  m_pt, m_bl, m_er, m_seen;
  frame_t      m_pub;
  frame_t      exp_q[$];

  always #5 clk = ~clk;

  seg_frame_capture_if #(.DIGITS(DIGITS)) bus ();

  seg_frame_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hex_out    (hex_out),
    .point_out  (point_out),
    .blank_mask (blank_mask),
    .err_mask   (err_mask),
    .valid      (valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_frame(input string tag, input frame_t f);
    check({tag, "_hex"},   32'(hex_out),    32'(f.hex));
    check({tag, "_point"}, 32'(point_out),  32'(f.pt));
    check({tag, "_blank"}, 32'(blank_mask), 32'(f.bl));
    check({tag, "_err"},   32'(err_mask),   32'(f.er));
  endtask

  // Frame-level reference: a dwell long enough is one digit capture; four distinct digits publish
  task automatic model_capture(input int idx, input logic [6:0] pat, input logic pbit);
    logic [3:0] nib = 4'h0;
    logic       b = 1'b0;
    logic       e = 1'b1;
    frame_t     f;
    for (int n = 0; n < 16; n++) begin
      if (seg_of_nibble(4'(n)) == pat) begin
        nib = 4'(n);
        e   = 1'b0;
      end
    end
    if (pat == 7'b1111111) begin
      b = 1'b1;
      e = 1'b0;
    end
    m_hex[4*idx +: 4] = nib;
    m_pt[idx] = ~pbit;
    m_bl[idx] = b;
    m_er[idx] = e;
    m_seen[idx] = 1'b1;
    if (m_seen == 4'hF) begin
      f = '{hex: m_hex, pt: m_pt, bl: m_bl, er: m_er};
      exp_q.push_back(f);
      exp_cnt++;
      m_seen = 4'h0;
    end
  endtask

  task automatic model_reset();
    m_hex = '0; m_pt = '0; m_bl = '0; m_er = '0; m_seen = '0;
    m_pub = '0;
  endtask

  task automatic drive_an(input logic [3:0] an, input int cyc);
    bus.AN = an;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic dwell(input int idx, input logic [6:0] pat, input logic pbit, input int cyc);
    logic [3:0] one;
    if (cyc >= LONG_MIN) model_capture(idx, pat, pbit);
    one = 4'b0001 << idx;
    bus.AN  = ~one;
    bus.LED = pat;
    bus.p   = pbit;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic dwell_glitch(input int idx, input logic [6:0] pre, input logic [6:0] post,
                              input logic pbit);
    logic [3:0] one;
    model_capture(idx, post, pbit);
    one = 4'b0001 << idx;
    bus.AN  = ~one;
    bus.p   = pbit;
    bus.LED = pre;
    repeat (2) @(negedge clk);
    bus.LED = post;
    repeat (8) @(negedge clk);
  endtask

  // Every valid pulse must match the oldest frame the model has completed
  always @(negedge clk) begin : mon
    frame_t f;
    if (!rst && valid) begin
      valid_cnt++;
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        f = exp_q.pop_front();
        m_pub = f;
        check_frame("publish", f);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, prev, cyc, r, vc;
    logic [6:0] pat;
    logic [3:0] an;

    model_reset();
    rst = 1'b1;
    bus.AN = 4'b1111; bus.LED = 7'b1111111; bus.p = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_hex",   32'(hex_out),    32'd0);
    check("reset_point", 32'(point_out),  32'd0);
    check("reset_blank", 32'(blank_mask), 32'd0);
    check("reset_err",   32'(err_mask),   32'd0);
    check("reset_valid", 32'(valid),      32'd0);

    // Full frame 3,A,0,F with the point on digit 1
    dwell(0, SEG_3, 1'b1, 8);
    dwell(1, SEG_A, 1'b0, 8);
    dwell(2, SEG_0, 1'b1, 8);
    dwell(3, SEG_F, 1'b1, 8);
    drive_an(4'b1111, 4);
    check("full_valid_count", 32'(valid_cnt), 32'd1);
    check_frame("full", '{hex: 16'hF0A3, pt: 4'b0010, bl: 4'b0000, er: 4'b0000});

    // Short dwell on digit 2 must not complete the frame
    vc = valid_cnt;
    dwell(0, SEG_5, 1'b1, 8);
    dwell(1, SEG_6, 1'b1, 8);
    dwell(2, SEG_9, 1'b1, 3);
    dwell(3, SEG_8, 1'b1, 8);
    drive_an(4'b1111, 6);
    check("short_no_valid", 32'(valid_cnt), 32'(vc));
    check_frame("short_hold", '{hex: 16'hF0A3, pt: 4'b0010, bl: 4'b0000, er: 4'b0000});
    dwell(2, SEG_7, 1'b1, 8);
    drive_an(4'b1111, 4);
    check("short_then_long_valid", 32'(valid_cnt), 32'(vc + 1));
    check_frame("short_frame", '{hex: 16'h8765, pt: 4'b0000, bl: 4'b0000, er: 4'b0000});

    // Blank on digit 0, illegal pattern on digit 3
    dwell(0, SEG_BLANK, 1'b1, 8);
    dwell(1, SEG_4, 1'b1, 8);
    dwell(2, SEG_C, 1'b0, 8);
    dwell(3, 7'b1010101, 1'b1, 8);
    drive_an(4'b1111, 4);
    check_frame("blank_err", '{hex: 16'h0C40, pt: 4'b0100, bl: 4'b0001, er: 4'b1000});

    // Illegal anode patterns mid-frame
    vc = valid_cnt;
    dwell(0, SEG_1, 1'b1, 8);
    dwell(1, SEG_2, 1'b1, 8);
    drive_an(4'b1100, 6);
    drive_an(4'b1111, 6);
    check("illegal_no_valid", 32'(valid_cnt), 32'(vc));
    check_frame("illegal_hold", '{hex: 16'h0C40, pt: 4'b0100, bl: 4'b0001, er: 4'b1000});
    dwell(2, SEG_3, 1'b1, 8);
    dwell(3, SEG_4, 1'b1, 8);
    drive_an(4'b1111, 4);
    check("illegal_valid", 32'(valid_cnt), 32'(vc + 1));
    check_frame("illegal_frame", '{hex: 16'h4321, pt: 4'b0000, bl: 4'b0000, er: 4'b0000});

    // Segment glitch early in the last dwell
    dwell(0, SEG_9, 1'b1, 8);
    dwell(1, SEG_B, 1'b1, 8);
    dwell(2, SEG_D, 1'b1, 8);
    dwell_glitch(3, SEG_7, SEG_E, 1'b1);
    drive_an(4'b1111, 4);
    check_frame("glitch", '{hex: 16'hEDB9, pt: 4'b0000, bl: 4'b0000, er: 4'b0000});

    // Reset after two captured digits discards them
    dwell(0, SEG_1, 1'b0, 8);
    dwell(1, SEG_2, 1'b0, 8);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_frame("midreset", '{hex: 16'h0000, pt: 4'b0000, bl: 4'b0000, er: 4'b0000});
    check("midreset_valid", 32'(valid), 32'd0);
    vc = valid_cnt;
    dwell(2, SEG_5, 1'b1, 8);
    dwell(3, SEG_6, 1'b1, 8);
    drive_an(4'b1111, 6);
    check("midreset_no_valid", 32'(valid_cnt), 32'(vc));
    dwell(0, SEG_7, 1'b1, 8);
    dwell(1, SEG_8, 1'b1, 8);
    drive_an(4'b1111, 4);
    check("midreset_valid_after", 32'(valid_cnt), 32'(vc + 1));
    check_frame("midreset_frame", '{hex: 16'h6587, pt: 4'b0000, bl: 4'b0000, er: 4'b0000});

    // Random scans: dwell length, order, patterns, points and illegal anodes
    prev = -1;
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(99, 0));
      if (r < 6) begin
        do an = 4'($urandom_range(15, 0)); while ($countones(~an) == 1);
        drive_an(an, int'($urandom_range(5, 1)));
        prev = -1;
      end else begin
        do idx = int'($urandom_range(3, 0)); while (idx == prev);
        prev = idx;
        cyc = (r < 30) ? int'($urandom_range(3, 1)) : int'($urandom_range(10, LONG_MIN));
        r = int'($urandom_range(99, 0));
        if (r < 70)      pat = seg_of_nibble(4'($urandom_range(15, 0)));
        else if (r < 80) pat = SEG_BLANK;
        else             pat = 7'($urandom_range(127, 0));
        dwell(idx, pat, 1'($urandom_range(1, 0)), cyc);
      end
    end
    drive_an(4'b1111, 10);
    check("rand_queue_drained", 32'(exp_q.size()), 32'd0);
    check("rand_valid_count", 32'(valid_cnt), 32'(exp_cnt));
    check_frame("rand_final_hold", m_pub);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_frame_capture.md
Name: seg_frame_capture

Overview:
- Snoops the multiplexed, active-low 4-digit seven-segment bus driven by the display scanner and hex-to-segment encoder.
- Reconstructs the displayed 16-bit hex value, the decimal points, blank digits and illegal patterns.
- Serves as the checking/readback end of the display interface: self-test of display paths on the board and a monitor in simulation.

Parameters:
- DIGITS, 4, number of multiplexed digits (anode lines).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- AN  input  DIGITS  anode selects, active-low, exactly one low when a digit is lit
- LED  input  7  segments, active-low; LED[6]=a … LED[0]=g
- p  input  1  decimal point as driven on the bus, active-low
- hex_out  output  4*DIGITS  captured nibbles; digit i at [4i+3:4i], i = index of AN bit
- point_out  output  DIGITS  1 = point lit on digit i
- blank_mask  output  DIGITS  1 = digit i showed all segments off
- err_mask  output  DIGITS  1 = digit i showed a non-hex pattern
- valid  output  1  one-cycle pulse when a complete frame is published

Behaviour:
- Reset: every output 0; state IDLE; seen mask, working registers and stability counter cleared. Reset mid-frame discards partial data; no valid pulse is generated.
- Inputs are registered once (the sample), then compared with the previous sample. "Stable" means {AN,LED,p} is unchanged from the previous sample.
- AN is legal only when exactly one bit is low. Decode index = position of the low bit.
- IDLE: wait for legal AN, then go to SETTLE with counter=1.
- SETTLE:
  - Stable and legal: counter++.
  - Counter reaches STABLE_CYCLES: go to CAPTURE.
  - Sample changes with AN still legal: restart counter at 1.
  - Illegal AN: go to IDLE.
- CAPTURE (1 cycle): decode LED into the working nibble/blank/err/point for the index, set seen[index], then go to WAIT_CHANGE.
  - If seen becomes all-ones in this cycle: copy working regs to the outputs, pulse valid next cycle, clear seen.
- WAIT_CHANGE:
  - AN changes to another legal value: go to SETTLE with counter=1.
  - AN becomes illegal: go to IDLE.
  - LED/p changes while AN is unchanged: ignored. Each digit is captured once per anode dwell.
- Decode table (LED -> nibble):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7
  - 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F
  - 1111111 -> nibble 0, blank=1.
  - Any other pattern -> nibble 0, err=1.
  - blank and err are never both 1.
- point_out[i] = ~p captured with digit i.
- Same digit captured twice before the frame completes: the latest capture overwrites.
- Latency: last digit's first stable sample + STABLE_CYCLES + 2 cycles to the valid pulse.
- Outputs change only in the publish cycle and hold between frames.

Decomposition:
- Package seg_pkg holds:
  - 7-bit segment constants SEG_0..SEG_F and SEG_BLANK
  - FSM state enum (IDLE, SETTLE, CAPTURE, WAIT_CHANGE)
  - the DIGITS default
- One combinational sub-module, seg_pattern_decode, takes LED and returns {nibble, blank, err}. The same table is reused by the bench scoreboard.

Test Plan:
- Full frame: scan AN 1110/1101/1011/0111, 8 cycles each, with digit patterns for 3,A,0,F and p=0 on digit 1 only.
  -> One valid pulse; hex_out=16'hF0A3, point_out=4'b0010, blank_mask=0, err_mask=0.
- Short dwell: STABLE_CYCLES=4, digit 2 held for 3 cycles only.
  -> No capture of digit 2; no valid until digit 2 is later held for ≥4 cycles.
- Blank and illegal patterns: digit 0 = 1111111, digit 3 = 1010101, others legal.
  -> blank_mask=4'b0001, err_mask=4'b1000, hex_out nibbles 0 and 3 = 0.
- Illegal anode: AN=1100 and then AN=1111 inserted mid-frame.
  -> FSM returns to IDLE; frame completes only after all four digits are captured legally; outputs unchanged until then.
- Glitch during settle: LED toggles on cycle 2 of a dwell.
  -> Counter restarts; the digit is captured with the post-glitch value.
- Reset mid-frame: rst asserted for 1 cycle after 2 digits are captured.
  -> All outputs 0; the next valid requires all 4 digits captured again.
